// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-bus arbiter: data-priority grant with lock until accepted,
// in-order owner tag FIFO that steers each response back to its requester.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction requester
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data requester
  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // shared bus side
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  typedef enum logic [1:0] {IDLE, LOCK_INST, LOCK_DATA} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tag_q [OUTSTANDING];
  logic               tag_d [OUTSTANDING];

  logic grant_inst, grant_data, grant_en;
  logic fifo_full, fifo_empty;
  logic push, pop, head_tag;

  // Grant selection: a locked grant wins, otherwise data has fixed priority
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      LOCK_INST: grant_inst = 1'b1;
      LOCK_DATA: grant_data = 1'b1;
      default: begin
        grant_data = data_sram_en;
        grant_inst = !data_sram_en && inst_sram_en;
      end
    endcase
  end

  assign fifo_full  = (count_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_q[rd_ptr_q];

  // Bus request, payload mux and handshake steering
  always_comb begin
    grant_en  = (grant_data && data_sram_en) || (grant_inst && inst_sram_en);
    bus_req   = grant_en && !fifo_full && !reset;
    bus_wr    = 1'b0;
    bus_size  = 2'b00;
    bus_wen   = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (grant_data) begin
      bus_wr    = data_sram_wr;
      bus_size  = data_sram_size;
      bus_wen   = data_sram_wen;
      bus_addr  = data_sram_addr;
      bus_wdata = data_sram_wdata;
    end else if (grant_inst) begin
      bus_wr    = inst_sram_wr;
      bus_size  = inst_sram_size;
      bus_wen   = inst_sram_wen;
      bus_addr  = inst_sram_addr;
      bus_wdata = inst_sram_wdata;
    end
    push              = bus_req && bus_addr_ok;
    pop               = bus_data_ok && !fifo_empty && !reset;
    inst_sram_addr_ok = push && grant_inst;
    data_sram_addr_ok = push && grant_data;
    inst_sram_data_ok = pop && !head_tag;
    data_sram_data_ok = pop && head_tag;
    inst_sram_rdata   = bus_rdata;
    data_sram_rdata   = bus_rdata;
  end

  // Next-state for grant lock and tag FIFO
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    case (state_q)
      IDLE: begin
        if (grant_data && !push)      state_d = LOCK_DATA;
        else if (grant_inst && !push) state_d = LOCK_INST;
      end
      LOCK_INST, LOCK_DATA: if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) begin
      tag_d[wr_ptr_q] = grant_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(OUTSTANDING); i++) tag_q[i] <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like bus port between the instruction-fetch requester (IF stage) and the data-access requester (EXE/MEM stages). It grants one address-phase request per handshake, records which requester owns each outstanding transaction in an in-order tag FIFO, and steers each `data_ok`/`rdata` response back to its owner. It sits between the pipeline's `inst_sram_*`/`data_sram_*` ports and the bus-side bridge.

## Interface
- `OUTSTANDING`, default 2: maximum in-flight transactions (tag FIFO depth, power of 2, ≥1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `inst_sram_en`, `inst_sram_wr`, `inst_sram_size[1:0]`, `inst_sram_wen[3:0]`, `inst_sram_addr[31:0]`, `inst_sram_wdata[31:0]`  in  instruction request.
- `inst_sram_addr_ok`, `inst_sram_data_ok`  out  1  instruction handshakes.
- `inst_sram_rdata`  out  32  instruction read data.
- `data_sram_en`, `data_sram_wr`, `data_sram_size[1:0]`, `data_sram_wen[3:0]`, `data_sram_addr[31:0]`, `data_sram_wdata[31:0]`  in  data request.
- `data_sram_addr_ok`, `data_sram_data_ok`  out  1  data handshakes.
- `data_sram_rdata`  out  32  data read data.
- `bus_req`, `bus_wr`, `bus_size[1:0]`, `bus_wen[3:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]`  out  shared request.
- `bus_addr_ok`, `bus_data_ok`  in  1  bus handshakes.
- `bus_rdata`  in  32  bus read data.

## Operation
- Requesters hold `en` and payload stable until they see `addr_ok`. Bus slave returns `data_ok` in request order.
- Grant state: `IDLE`, `LOCK_INST`, `LOCK_DATA`.
  - `IDLE`: if `data_sram_en`, grant data; else if `inst_sram_en`, grant inst. Data has fixed priority.
  - If the granted request is not accepted (`bus_addr_ok`=0) in that cycle, enter `LOCK_x`. The grant then holds until `bus_addr_ok` even if the other requester raises `en`; `LOCK_x` returns to `IDLE` on `bus_addr_ok`.
  - If accepted in the same cycle, stay in `IDLE`.
- `bus_req` = granted `en` AND NOT fifo_full AND NOT `reset`. Payload is muxed from the granted requester; it is all-zero when nothing is granted.
- `x_addr_ok` = `bus_addr_ok` AND `bus_req` AND grant==x. Only one of the two is ever high.
- Accepted handshake pushes tag (0=inst, 1=data) into the FIFO.
- `bus_data_ok` with FIFO non-empty pops the head and raises `x_data_ok` for the head tag.
- `bus_rdata` is broadcast to both `rdata` outputs unchanged.
- FIFO full: `bus_req`=0. A pop in the same cycle does not enable a push; the push waits one cycle.
- Push and pop in the same cycle with FIFO non-full: both happen, and count is unchanged.
- `bus_data_ok` with FIFO empty is a protocol error: ignored, no `data_ok` output, no state change.
- Pointers are `$clog2(OUTSTANDING)` bits and wrap modulo depth. Count is one bit wider.
- Reset mid-operation: FIFO emptied and grant set to `IDLE` on that edge. Responses for pre-reset transactions are dropped as empty-FIFO errors.

## Timing
- Reset values: state `IDLE`, FIFO count 0, pointers 0. While `reset`=1, `bus_req`, both `addr_ok` and both `data_ok` are 0.
- Address path is combinational, zero cycles from requester `en` to `bus_req`.
- `x_addr_ok` and `x_data_ok` are combinational from `bus_addr_ok` and `bus_data_ok` in the same cycle.
- Back-to-back acceptance: one request per cycle while not full.
- Tag visibility: a push on edge N is visible for a pop in cycle N+1 onward. `addr_ok` and `data_ok` in the same cycle for the same transaction are not supported.
- The grant decision uses only current-cycle `en` and registered state. There are no combinational loops through `addr_ok`.

## Test plan
1. **Simultaneous requests.** Inst and data `en` rise together, `bus_addr_ok`=1 → data granted first (`bus_addr`=data addr, `data_sram_addr_ok`=1), inst next cycle. Return `bus_data_ok` twice with rdata 0x11111111, then 0x22222222 → `data_sram_data_ok` gets 0x11111111, then `inst_sram_data_ok` gets 0x22222222.
2. **Grant lock.** Inst granted with `bus_addr_ok`=0 for 3 cycles. Data `en` rises in cycle 1 → `bus_addr` stays the inst addr and data is blocked until the inst `addr_ok` cycle. Data is granted in the following cycle.
3. **Full FIFO.** `OUTSTANDING`=2: two accepted inst fetches with no `data_ok` → third request sees `bus_req`=0. A `bus_data_ok` cycle does not accept; `bus_req`=1 resumes the next cycle.
4. **Wrap-around.** Issue 5 interleaved inst/data requests with one response per cycle lag → all 5 `data_ok` outputs go to the correct owner in order, with pointers wrapping twice.
5. **Spurious response.** `bus_data_ok`=1 with FIFO empty → both `data_ok` outputs stay 0 and count stays 0.
6. **Reset mid-operation.** Assert `reset` with 2 outstanding and the state in `LOCK_DATA` → next cycle count=0, state `IDLE`, and `bus_req`=0 during reset.
